// File: rtl/multiplier_32b_arbiter_pkg.sv
// Shared constants and FSM state type for the shared-multiplier arbiter.
package multiplier_32b_arbiter_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;

  // IDLE: no result held; RESP: a product is waiting on the response channel.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

endpackage

// File: rtl/multiplier_32b_arbiter_if.sv
// Request/response bundle between the compute clients and the arbiter.
// Signal names carry the arbiter's point of view (i* = into the arbiter).
interface multiplier_32b_arbiter_if
  import multiplier_32b_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       iReqValid;
  logic [NUM_REQ*MUL_W-1:0] iReqData0;
  logic [NUM_REQ*MUL_W-1:0] iReqData1;
  logic [NUM_REQ-1:0]       oReqReady;
  logic                     oRspValid;
  logic [ID_W-1:0]          oRspId;
  logic [PROD_W-1:0]        oRspData;
  logic                     iRspReady;

  // Arbiter side.
  modport slave (
    input  iReqValid, iReqData0, iReqData1, iRspReady,
    output oReqReady, oRspValid, oRspId, oRspData
  );

  // Client / consumer side.
  modport master (
    output iReqValid, iReqData0, iReqData1, iRspReady,
    input  oReqReady, oRspValid, oRspId, oRspData
  );

endinterface

// File: rtl/multiplier_32b_arbiter_mulreg.sv
// Registered 32x32->64 unsigned multiplier shared by all requesters.
module multiplier_32b_reg
  import multiplier_32b_arbiter_pkg::*;
(
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iClr,
  input  logic              iEn,
  input  logic [MUL_W-1:0]  iData0,
  input  logic [MUL_W-1:0]  iData1,
  output logic [PROD_W-1:0] oData
);

  logic [PROD_W-1:0] prod_q;

  // Capture the full-width product on enable; clear has priority.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      prod_q <= '0;
    end else if (iClr) begin
      prod_q <= '0;
    end else if (iEn) begin
      prod_q <= PROD_W'(iData0) * PROD_W'(iData1);
    end
  end

  assign oData = prod_q;

endmodule

// File: rtl/multiplier_32b_arbiter.sv
// Round-robin arbiter sharing one registered multiplier among NUM_REQ clients,
// with a single-entry valid/ready response slot.
module multiplier_32b_arbiter
  import multiplier_32b_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iClr,
  multiplier_32b_arbiter_if.slave  bus,
  output logic [31:0]              oOpCnt
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       cnt_q, cnt_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic              slot_free;
  logic              grant;
  logic [MUL_W-1:0]  op_a, op_b;
  logic [PROD_W-1:0] prod;

  // Find the first valid requester scanning from ptr upward, wrapping.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.iReqValid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free = (state_q == IDLE) || (state_q == RESP && bus.iRspReady);
  assign grant     = slot_free && found && !iClr && iRstN;

  assign op_a = bus.iReqData0[MUL_W*win +: MUL_W];
  assign op_b = bus.iReqData1[MUL_W*win +: MUL_W];

  // FSM state register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: clear wins, then a new grant keeps/enters RESP, then drain.
  always_comb begin
    state_d = state_q;
    if (iClr) begin
      state_d = IDLE;
    end else if (grant) begin
      state_d = RESP;
    end else if (state_q == RESP && bus.iRspReady) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: response valid and the one-hot grant.
  always_comb begin
    bus.oRspValid = (state_q == RESP);
    bus.oReqReady = '0;
    if (grant) begin
      bus.oReqReady[win] = 1'b1;
    end
  end

  // Next values for pointer, response tag and operation counter.
  always_comb begin
    ptr_d    = ptr_q;
    rsp_id_d = rsp_id_q;
    cnt_d    = cnt_q;
    if (iClr) begin
      ptr_d    = '0;
      rsp_id_d = '0;
      cnt_d    = '0;
    end else if (grant) begin
      ptr_d    = ID_W'((int'(win) + 1) % NUM_REQ);
      rsp_id_d = win;
      cnt_d    = cnt_q + 32'd1;
    end
  end

  // Pointer, response tag and operation counter registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ptr_q    <= '0;
      rsp_id_q <= '0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rsp_id_q <= rsp_id_d;
      cnt_q    <= cnt_d;
    end
  end

  multiplier_32b_reg u_mul (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClr   (iClr),
    .iEn    (grant),
    .iData0 (op_a),
    .iData1 (op_b),
    .oData  (prod)
  );

  assign bus.oRspData = prod;
  assign bus.oRspId   = rsp_id_q;
  assign oOpCnt       = cnt_q;

endmodule

// File: tb/tb_multiplier_32b_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized traffic against a transaction-level model of the arbiter.
module tb_multiplier_32b_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iClr;
  logic [31:0] op_cnt;

  multiplier_32b_arbiter_if #(.NUM_REQ(N)) bus ();

  multiplier_32b_arbiter #(.NUM_REQ(N)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClr   (iClr),
    .bus    (bus.slave),
    .oOpCnt (op_cnt)
  );

  always #5 iClk = ~iClk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: one result slot, a rotating priority start, a count.
  bit              m_have;
  int              m_id;
  longint unsigned m_prod;
  int              m_ptr;
  int unsigned     m_cnt;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_have = 0; m_id = 0; m_prod = 0; m_ptr = 0; m_cnt = 0;
  endfunction

  function automatic int model_winner();
    for (int j = 0; j < N; j++) begin
      int k;
      k = (m_ptr + j) % N;
      if (bus.iReqValid[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.iReqValid[k] = 1'b1;
    bus.iReqData0[32*k +: 32] = a;
    bus.iReqData1[32*k +: 32] = b;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs already set.
  task automatic cycle(output logic [N-1:0] rdy);
    logic [N-1:0] exp_rdy;
    int w;
    bit free;
    #1;
    w = model_winner();
    free = !m_have || bus.iRspReady;
    exp_rdy = '0;
    if (free && !iClr && w >= 0) exp_rdy[w] = 1'b1;
    rdy = bus.oReqReady;
    check("req_ready", rdy, exp_rdy);
    @(posedge iClk);
    if (iClr) begin
      m_have = 0; m_ptr = 0; m_cnt = 0; m_id = 0; m_prod = 0;
    end else if (exp_rdy != '0) begin
      m_prod = 64'(bus.iReqData0[32*w +: 32]) * 64'(bus.iReqData1[32*w +: 32]);
      m_id   = w;
      m_ptr  = (w + 1) % N;
      m_cnt++;
      m_have = 1;
    end else if (m_have && bus.iRspReady) begin
      m_have = 0;
    end
    #1;
    check("rsp_valid", bus.oRspValid, m_have);
    check("op_cnt", op_cnt, m_cnt);
    if (m_have) begin
      check("rsp_id", bus.oRspId, m_id);
      check("rsp_data", bus.oRspData, m_prod);
    end
    @(negedge iClk);
  endtask

  initial begin
    logic [N-1:0] rdy;
    logic [63:0]  held_data;
    logic [IW-1:0] held_id;

    tbl[0] = '{2, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    tbl[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{0, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    tbl[3] = '{3, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    tbl[4] = '{3, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    tbl[5] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{0, 32'h0001_0000, 32'hFFFF_FFFF, 64'h0000_FFFF_FFFF_0000};
    tbl[7] = '{1, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340};

    // Reset with every requester asserting valid: no grant may leak out.
    iRstN = 1'b0;
    iClr  = 1'b0;
    bus.iReqValid = '1;
    bus.iReqData0 = '0;
    bus.iReqData1 = '0;
    bus.iRspReady = 1'b1;
    model_reset();
    repeat (2) @(negedge iClk);
    check("rst_ready", bus.oReqReady, 0);
    check("rst_rsp_valid", bus.oRspValid, 0);
    check("rst_rsp_id", bus.oRspId, 0);
    check("rst_rsp_data", bus.oRspData, 0);
    check("rst_op_cnt", op_cnt, 0);
    bus.iReqValid = '0;
    iRstN = 1'b1;

    // Directed single-requester products.
    for (int i = 0; i < 8; i++) begin
      bus.iReqValid = '0;
      set_req(tbl[i].r, tbl[i].a, tbl[i].b);
      cycle(rdy);
      check("tbl_grant", rdy, 1 << tbl[i].r);
      check("tbl_id", bus.oRspId, tbl[i].r);
      check("tbl_product", bus.oRspData, tbl[i].p);
      check("tbl_cnt", op_cnt, i + 1);
    end
    bus.iReqValid = '0;
    cycle(rdy);
    check("drain_valid", bus.oRspValid, 0);

    // Fairness: start from a cleared pointer, all four requesters pending.
    iClr = 1'b1;
    cycle(rdy);
    iClr = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, 32'h100 + k, 32'h7 + k);
    for (int i = 0; i < 8; i++) begin
      cycle(rdy);
      check("fair_grant", rdy, 1 << (i % N));
    end
    check("fair_cnt", op_cnt, 8);

    // Back-pressure: result from requester 3 (0x103 * 0xA) must sit still.
    bus.iRspReady = 1'b0;
    held_data = bus.oRspData;
    held_id   = bus.oRspId;
    check("bp_held_data", held_data, 64'h0A1E);
    check("bp_held_id", held_id, 3);
    for (int i = 0; i < 5; i++) begin
      cycle(rdy);
      check("bp_ready_low", rdy, 0);
      check("bp_data_stable", bus.oRspData, held_data);
      check("bp_id_stable", bus.oRspId, held_id);
    end
    bus.iRspReady = 1'b1;
    cycle(rdy);
    check("bp_release_grant", rdy, 4'b0001);

    // Clear while holding a result with requests pending.
    iClr = 1'b1;
    cycle(rdy);
    iClr = 1'b0;
    check("clr_rsp_valid", bus.oRspValid, 0);
    check("clr_rsp_data", bus.oRspData, 0);
    check("clr_rsp_id", bus.oRspId, 0);
    check("clr_op_cnt", op_cnt, 0);
    bus.iReqValid = 4'b1001;
    cycle(rdy);
    check("clr_priority", rdy, 4'b0001);

    // Asynchronous reset in the middle of back-to-back traffic.
    bus.iReqValid = '1;
    cycle(rdy);
    cycle(rdy);
    @(posedge iClk);
    #2;
    iRstN = 1'b0;
    #1;
    check("arst_ready", bus.oReqReady, 0);
    check("arst_rsp_valid", bus.oRspValid, 0);
    check("arst_rsp_id", bus.oRspId, 0);
    check("arst_rsp_data", bus.oRspData, 0);
    check("arst_op_cnt", op_cnt, 0);
    @(negedge iClk);
    bus.iReqValid = '0;
    model_reset();
    @(negedge iClk);
    iRstN = 1'b1;
    cycle(rdy);
    check("arst_no_rsp", bus.oRspValid, 0);

    // Randomized traffic: requesters hold valid/data until granted.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.iReqValid[k] && ($urandom % 3 == 0)) begin
          case ($urandom % 4)
            0:       set_req(k, 32'hFFFF_FFFF, $urandom);
            1:       set_req(k, $urandom, 32'hFFFF_FFFF);
            default: set_req(k, $urandom, $urandom);
          endcase
        end
      end
      bus.iRspReady = ($urandom % 4 != 0);
      iClr = ($urandom % 50 == 0);
      cycle(rdy);
      bus.iReqValid = bus.iReqValid & ~rdy;
    end
    iClr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
